// File: rtl/enc_pkg.sv
// Shared constants and helpers for the priority-encoder family.
// Mode encodings are shared by the top level and any software model.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an n-wide request vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational first-set-bit search that starts at an arbitrary position and wraps.
// The vector is rotated by start, the lowest set bit is found, and the index is un-rotated.
module prio_find
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    localparam logic [W:0] N_W = (W+1)'(N);

    // Modulo-N add; both operands are < N so one conditional subtract suffices.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_W) begin
            s = s - N_W;
        end
        return s[W-1:0];
    endfunction

    logic [N-1:0] w_rot;
    logic [W-1:0] w_first;

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = vec[wrap_add(W'(i), start)];
        end
        w_first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = W'(i);
            end
        end
    end

    assign found = |w_rot;
    assign idx   = found ? wrap_add(w_first, start) : '0;

endmodule

// File: rtl/prio_encoder_rr.sv
// Request-vector encoder with a one-beat registered valid/ready output stage,
// fixed-priority or round-robin resolution, and zero/multi-hot/popcount flags.
module prio_encoder_rr
    import enc_pkg::*;
#(
    parameter  int N_IN  = 8,
    localparam int IDX_W = idx_width(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  req_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_any,
    output logic             out_multi,
    output logic [IDX_W:0]   out_count
);

    if (N_IN < 2) begin : g_bad_width
        $error("prio_encoder_rr: N_IN must be >= 2");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_any;
    logic             r_out_multi;
    logic [IDX_W:0]   r_out_count;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [N_IN-1:0]  w_rev;
    logic [N_IN-1:0]  w_search;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_found_idx;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W:0]   w_count;
    logic             w_multi;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_capture;

    // Fixed priority searches the bit-reversed vector from 0, so the lowest hit
    // there is the highest set bit of req_vec.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_rev[i] = req_vec[N_IN-1-i];
        end
        w_search = (mode == MODE_RR) ? req_vec : w_rev;
        w_start  = (mode == MODE_RR) ? r_rr_ptr : '0;
    end

    prio_find #(
        .N (N_IN),
        .W (IDX_W)
    ) u_find (
        .vec   (w_search),
        .start (w_start),
        .idx   (w_found_idx),
        .found (w_found)
    );

    always_comb begin
        w_idx = '0;
        if (w_found) begin
            w_idx = (mode == MODE_RR) ? w_found_idx : (LAST_IDX - w_found_idx);
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_count = w_count + (IDX_W+1)'(req_vec[i]);
        end
        w_multi = (w_count > (IDX_W+1)'(1));
    end

    // Explicit wrap keeps the pointer in range for non-power-of-2 widths.
    assign w_ptr_next = (w_idx == LAST_IDX) ? '0 : (w_idx + IDX_W'(1));

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_any   <= 1'b0;
            r_out_multi <= 1'b0;
            r_out_count <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= w_idx;
                r_out_any   <= w_found;
                r_out_multi <= w_multi;
                r_out_count <= w_count;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_capture && w_found) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_any   = r_out_any;
    assign out_multi = r_out_multi;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr at N_IN=8 and N_IN=5 with hand-computed results.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       mode, in_valid, in_ready, out_valid, out_ready, out_any, out_multi;
    logic [7:0] req_vec;
    logic [2:0] out_idx;
    logic [3:0] out_count;

    logic       mode5, in_valid5, in_ready5, out_valid5, out_ready5, out_any5, out_multi5;
    logic [4:0] req_vec5;
    logic [2:0] out_idx5;
    logic [3:0] out_count5;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N_IN(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req_vec   (req_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_any   (out_any),
        .out_multi (out_multi),
        .out_count (out_count)
    );

    prio_encoder_rr #(.N_IN(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .req_vec   (req_vec5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_idx   (out_idx5),
        .out_any   (out_any5),
        .out_multi (out_multi5),
        .out_count (out_count5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input logic m, input logic [7:0] v, input logic vld, input logic rdy);
        mode      = m;
        req_vec   = v;
        in_valid  = vld;
        out_ready = rdy;
    endtask

    task automatic apply5(input logic m, input logic [4:0] v, input logic vld, input logic rdy);
        mode5      = m;
        req_vec5   = v;
        in_valid5  = vld;
        out_ready5 = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        apply5(1'b0, 5'h00, 1'b0, 1'b1);

        // T1 reset
        #4;
        check("rst_valid", out_valid, 0);
        check("rst_idx",   out_idx,   0);
        check("rst_any",   out_any,   0);
        check("rst_multi", out_multi, 0);
        check("rst_count", out_count, 0);
        check("rst_ready", in_ready,  1);
        #8;
        rst_n = 1'b1;
        apply(1'b0, 8'b0010_0000, 1'b1, 1'b1);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_idx",   out_idx,   5);
        check("t1_count", out_count, 1);
        check("t1_multi", out_multi, 0);
        check("t1_any",   out_any,   1);

        // T2 fixed priority, highest index wins
        apply(1'b0, 8'b1000_0001, 1'b1, 1'b1);
        step();
        check("t2_idx",   out_idx,   7);
        check("t2_count", out_count, 2);
        check("t2_multi", out_multi, 1);
        check("t2_any",   out_any,   1);

        // T3 round-robin from rr_ptr=0, back-to-back beats
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        reset_pulse();
        apply(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        step();
        check("t3_idx_a", out_idx, 0);
        step();
        check("t3_idx_b", out_idx, 7);
        step();
        check("t3_idx_c", out_idx, 0);
        check("t3_valid", out_valid, 1);
        apply(1'b1, 8'h00, 1'b0, 1'b1);
        step();
        check("t3_drain_valid", out_valid, 0);

        // T4 backpressure; mode/vec change during the hold must not leak through
        apply(1'b0, 8'b0000_1000, 1'b1, 1'b0);
        step();
        check("t4_cap_valid", out_valid, 1);
        check("t4_cap_idx",   out_idx,   3);
        apply(1'b1, 8'b0000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_ready", in_ready, 0);
            step();
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_idx",   out_idx,   3);
            check("t4_hold_count", out_count, 1);
        end
        apply(1'b0, 8'b0100_0000, 1'b1, 1'b1);
        #1;
        check("t4_release_ready", in_ready, 1);
        step();
        check("t4_next_valid", out_valid, 1);
        check("t4_next_idx",   out_idx,   6);

        // T5 zero input leaves rr_ptr alone (pointer is 7 after the idx-6 capture)
        apply(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        step();
        check("t5_pre_idx", out_idx, 7);
        apply(1'b1, 8'h00, 1'b1, 1'b1);
        step();
        check("t5_valid", out_valid, 1);
        check("t5_any",   out_any,   0);
        check("t5_idx",   out_idx,   0);
        check("t5_count", out_count, 0);
        check("t5_multi", out_multi, 0);
        apply(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        step();
        check("t5_post_idx", out_idx, 0);

        // T6 async reset while holding; pointer is 1 before the reset
        apply(1'b1, 8'b0000_0001, 1'b1, 1'b0);
        step();
        check("t6_hold_valid", out_valid, 1);
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_idx",   out_idx,   0);
        check("t6_rst_ready", in_ready,  1);
        rst_n = 1'b1;
        apply(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        step();
        check("t6_ptr_idx", out_idx, 0);
        apply(1'b0, 8'h00, 1'b0, 1'b1);

        // N_IN=5: fixed priority and round-robin with wrap from 4
        apply5(1'b0, 5'b10001, 1'b1, 1'b1);
        step();
        check("n5_t2_idx",   out_idx5,   4);
        check("n5_t2_count", out_count5, 2);
        check("n5_t2_multi", out_multi5, 1);
        check("n5_t2_any",   out_any5,   1);
        apply5(1'b0, 5'h00, 1'b0, 1'b1);
        reset_pulse();
        apply5(1'b1, 5'b10001, 1'b1, 1'b1);
        step();
        check("n5_t3_idx_a", out_idx5, 0);
        step();
        check("n5_t3_idx_b", out_idx5, 4);
        step();
        check("n5_t3_idx_c", out_idx5, 0);
        apply5(1'b1, 5'b11111, 1'b1, 1'b1);
        step();
        check("n5_full_idx",   out_idx5,   1);
        check("n5_full_count", out_count5, 5);
        apply5(1'b1, 5'h00, 1'b0, 1'b1);
        step();
        check("n5_drain_valid", out_valid5, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion",
                 n_total);
        $fatal(1);
    end

endmodule
